// File: rtl/maxterm_scanner.sv
// maxterm_scanner
//   Walks every input combination of an N-input combinational function under
//   test (FUT). Each vector is held for SETTLE cycles before f is sampled.
//   The block builds the full truth table and counts the maxterms (rows with
//   f = 0). When the optional stream is compiled in, it also emits one pulse
//   per maxterm carrying that row's index.
//
//   Optional feature macro: MAXTERM_SCANNER_STREAM_EN (adds mt_valid/mt_idx).
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset; has priority over everything
//     start     begin a scan (accepted only while idle, never queued)
//     x[N]      vector driven to the FUT (MSB = first variable)
//     f         FUT output for the current x
//     busy      high while scanning
//     done      one-cycle pulse after the last row is sampled
//     mask[2^N] truth table, bit i = f sampled with x = i
//     zeros     number of maxterms found (N+1 bits so 2^N fits)
//     mt_valid  pulse per maxterm sampled   (stream build only)
//     mt_idx    index of that maxterm        (stream build only)
module maxterm_scanner #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N-1:0]      x,
  input  logic              f,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   mask,
  output logic [N:0]        zeros
`ifdef MAXTERM_SCANNER_STREAM_EN
  ,
  output logic              mt_valid,
  output logic [N-1:0]      mt_idx
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
  localparam logic [N-1:0] X_LAST   = {N{1'b1}};

  state_t            state_q, state_d;
  logic [N-1:0]      x_q, x_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2**N-1:0]   mask_q, mask_d;
  logic [N:0]        zeros_q, zeros_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MAXTERM_SCANNER_STREAM_EN
  logic              mt_valid_q, mt_valid_d;
  logic [N-1:0]      mt_idx_q, mt_idx_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    zeros_d = zeros_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MAXTERM_SCANNER_STREAM_EN
    mt_valid_d = 1'b0;          // pulse only on edges that sample a maxterm
    mt_idx_d   = mt_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_d     = '0;
          cnt_d   = '0;
          mask_d  = '0;
          zeros_d = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        // cnt runs 0..SETTLE; the edge that finds cnt == SETTLE samples f,
        // so x has been stable for SETTLE full cycles by then.
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          mask_d[x_q] = f;
          if (!f) begin
            zeros_d = zeros_q + (N+1)'(1);
`ifdef MAXTERM_SCANNER_STREAM_EN
            mt_valid_d = 1'b1;
            mt_idx_d   = x_q;
`endif
          end
          if (x_q == X_LAST) begin
            state_d = DONE;     // x stays at 2^N-1 afterwards
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d   = x_q + N'(1);
            cnt_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;         // start is deliberately not looked at here
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      zeros_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MAXTERM_SCANNER_STREAM_EN
      mt_valid_q <= 1'b0;
      mt_idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      zeros_q <= zeros_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MAXTERM_SCANNER_STREAM_EN
      mt_valid_q <= mt_valid_d;
      mt_idx_q   <= mt_idx_d;
`endif
    end
  end

  assign x     = x_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign mask  = mask_q;
  assign zeros = zeros_q;
`ifdef MAXTERM_SCANNER_STREAM_EN
  assign mt_valid = mt_valid_q;
  assign mt_idx   = mt_idx_q;
`endif

endmodule
